// File: rtl/shift_arbiter_ctrl.sv
// Two-requester round-robin front end for a shared 16-bit logarithmic shifter.
// Optional sign-filling right shifts are enabled by defining SHIFT_ARITH_EN.
module shift_arbiter_ctrl #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_data,
  input  logic [SHW-1:0]   req0_shamt,
  input  logic             req0_left,
  input  logic             req0_arith,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_data,
  input  logic [SHW-1:0]   req1_shamt,
  input  logic             req1_left,
  input  logic             req1_arith,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             busy
);

  localparam int unsigned STEPW = (SHW > 1) ? $clog2(SHW) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Operation attributes captured on the accept edge.
  typedef struct packed {
    logic           id;
    logic           left;
    logic           fill;
    logic [SHW-1:0] shamt;
  } op_t;

  state_t           state_q, state_d;
  logic [STEPW-1:0] step_q, step_d;
  logic             prio_q, prio_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_id_q, res_id_d;
  logic             busy_q, busy_d;

  logic             grant0, grant1;
  logic             fill_new;
  logic [SHW-1:0]   stage_amt;
  logic [WIDTH-1:0] stage_mask;
  logic [WIDTH-1:0] stage_out;

  // Round-robin grant; readies stay low while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && rst_n) begin
      grant1 = req1_valid && (!req0_valid || prio_q);
      grant0 = req0_valid && !grant1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

`ifdef SHIFT_ARITH_EN
  // Sign fill decided once at accept: right shift, arith requested, negative operand.
  assign fill_new = grant1 ? (!req1_left && req1_arith && req1_data[WIDTH-1])
                           : (!req0_left && req0_arith && req0_data[WIDTH-1]);
`else
  logic unused_arith;
  assign fill_new     = 1'b0;
  assign unused_arith = req0_arith ^ req1_arith;
`endif

  // One log stage: shift by 2^step when the matching shamt bit is set.
  always_comb begin
    stage_amt  = SHW'(1) << step_q;
    stage_mask = ~({WIDTH{1'b1}} >> stage_amt);
    stage_out  = work_q;
    if (op_q.shamt[step_q]) begin
      if (op_q.left) stage_out = work_q << stage_amt;
      else           stage_out = (work_q >> stage_amt) | (op_q.fill ? stage_mask : '0);
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    prio_d      = prio_q;
    op_d        = op_q;
    work_d      = work_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          op_d.id    = grant1;
          op_d.left  = grant1 ? req1_left  : req0_left;
          op_d.shamt = grant1 ? req1_shamt : req0_shamt;
          op_d.fill  = fill_new;
          work_d     = grant1 ? req1_data  : req0_data;
          step_d     = '0;
          prio_d     = grant0;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        work_d = stage_out;
        step_d = step_q + STEPW'(1);
        if (step_q == STEPW'(SHW - 1)) begin
          step_d      = '0;
          res_data_d  = stage_out;
          res_id_d    = op_q.id;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      step_q      <= '0;
      prio_q      <= 1'b0;
      op_q        <= '0;
      work_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      prio_q      <= prio_d;
      op_q        <= op_d;
      work_q      <= work_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      busy_q      <= busy_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = busy_q;

endmodule
